// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single data RAM: fixed priority to port 0, bounded wait for port 1, optional burst lock.
// Grants are combinational, RAM commands are registered one cycle later, and read data returns RD_LAT cycles after that.
module ram_arbiter #(
    parameter int AWIDTH   = 8,
    parameter int DWIDTH   = 16,
    parameter int MAX_WAIT = 4,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [AWIDTH-1:0] p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DWIDTH-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [AWIDTH-1:0] p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DWIDTH-1:0] p1_rdata,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [AWIDTH-1:0] ram_raddr,
    output logic [AWIDTH-1:0] ram_waddr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} own_t;

    own_t            state;
    own_t            state_nxt;
    logic [SW-1:0]   starve;
    logic            gnt_any;
    logic            we_sel;
    logic [AWIDTH-1:0] addr_sel;
    logic [DWIDTH-1:0] wdata_sel;
    logic [RD_LAT:0] tag_vld;
    logic [RD_LAT:0] tag_port;

    always_ff @(posedge clk) begin
        if (rst) state <= OWN_NONE;
        else     state <= state_nxt;
    end

    // A new locked grant takes ownership; otherwise the current owner keeps it only while its lock stays high.
    always_comb begin
        state_nxt = OWN_NONE;
        if (p0_gnt && p0_lock)
            state_nxt = OWN_P0;
        else if (p1_gnt && p1_lock)
            state_nxt = OWN_P1;
        else if (state == OWN_P0 && p0_lock)
            state_nxt = OWN_P0;
        else if (state == OWN_P1 && p1_lock)
            state_nxt = OWN_P1;
    end

    // A dropped lock falls through to normal arbitration in the same cycle.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (state == OWN_P0 && p0_lock)
                p0_gnt = p0_req;
            else if (state == OWN_P1 && p1_lock)
                p1_gnt = p1_req;
            else if (starve == STARVE_MAX && p1_req)
                p1_gnt = 1'b1;
            else if (p0_req)
                p0_gnt = 1'b1;
            else if (p1_req)
                p1_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            starve <= '0;
        else if (!p1_req || p1_gnt)
            starve <= '0;
        else if (starve != STARVE_MAX)
            starve <= starve + 1'b1;
    end

    assign gnt_any   = p0_gnt | p1_gnt;
    assign we_sel    = p0_gnt ? p0_we    : p1_we;
    assign addr_sel  = p0_gnt ? p0_addr  : p1_addr;
    assign wdata_sel = p0_gnt ? p0_wdata : p1_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_raddr <= '0;
            ram_waddr <= '0;
            ram_wdata <= '0;
        end else begin
            ram_rd <= gnt_any & ~we_sel;
            ram_wr <= gnt_any & we_sel;
            if (gnt_any) begin
                ram_raddr <= addr_sel;
                ram_waddr <= addr_sel;
                ram_wdata <= wdata_sel;
            end
        end
    end

    // Read tags ride alongside the RAM pipeline so the response is steered back to its requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld  <= '0;
            tag_port <= '0;
        end else begin
            tag_vld  <= {tag_vld[RD_LAT-1:0],  gnt_any & ~we_sel};
            tag_port <= {tag_port[RD_LAT-1:0], p1_gnt};
        end
    end

    assign p0_rvalid = tag_vld[RD_LAT] & ~tag_port[RD_LAT];
    assign p1_rvalid = tag_vld[RD_LAT] &  tag_port[RD_LAT];
    assign p0_rdata  = ram_rdata;
    assign p1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, reference arbitration model and a read-return scoreboard.
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          ram_rd, ram_wr;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MAX_WAIT), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_waddr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_raddr];
    end

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            cyc;
    } rd_t;

    rd_t           sb[$];
    logic [DW-1:0] shadow [256];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    logic          m_own_vld = 1'b0, m_own = 1'b0;
    int            m_starve = 0;
    logic          m_rd = 1'b0, m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          obs_g0, obs_g1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: compare DUT against the model at negedge, advance the model, return just after posedge.
    task automatic step();
        logic g0, g1, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rd_t e;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (m_own_vld && !m_own && p0_lock)     g0 = p0_req;
            else if (m_own_vld && m_own && p1_lock) g1 = p1_req;
            else if (m_starve == MAX_WAIT && p1_req) g1 = 1'b1;
            else if (p0_req)                        g0 = 1'b1;
            else if (p1_req)                        g1 = 1'b1;
        end
        obs_g0 = p0_gnt;
        obs_g1 = p1_gnt;
        chk("p0_gnt", {31'b0, p0_gnt}, {31'b0, g0});
        chk("p1_gnt", {31'b0, p1_gnt}, {31'b0, g1});
        chk("ram_rd", {31'b0, ram_rd}, {31'b0, m_rd});
        chk("ram_wr", {31'b0, ram_wr}, {31'b0, m_wr});
        chk("ram_raddr", {24'b0, ram_raddr}, {24'b0, m_addr});
        chk("ram_waddr", {24'b0, ram_waddr}, {24'b0, m_addr});
        chk("ram_wdata", {16'b0, ram_wdata}, {16'b0, m_wdata});
        if (p0_rvalid || p1_rvalid) begin
            chk("rvalid_both", {31'b0, p0_rvalid & p1_rvalid}, 32'd0);
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rvalid_port", {31'b0, p1_rvalid}, {31'b0, e.port});
                chk("rdata", {16'b0, (p1_rvalid ? p1_rdata : p0_rdata)}, {16'b0, e.data});
                chk("rd_latency", cyc - e.cyc, 32'd2);
            end
        end
        if (sb.size() != 0 && cyc > sb[0].cyc + 2) begin
            e = sb.pop_front();
            chk("rvalid_missing", cyc - e.cyc, 32'd2);
        end
        if (rst) begin
            m_own_vld = 1'b0;
            m_starve  = 0;
            m_rd      = 1'b0;
            m_wr      = 1'b0;
            m_addr    = '0;
            m_wdata   = '0;
            sb.delete();
        end else begin
            m_rd = 1'b0;
            m_wr = 1'b0;
            if (g0 || g1) begin
                we = g0 ? p0_we : p1_we;
                a  = g0 ? p0_addr : p1_addr;
                d  = g0 ? p0_wdata : p1_wdata;
                m_rd = !we;
                m_wr = we;
                m_addr = a;
                m_wdata = d;
                if (we) shadow[a] = d;
                else    sb.push_back('{port: g1, data: shadow[a], cyc: cyc});
            end
            if (g0 && p0_lock)                         begin m_own_vld = 1'b1; m_own = 1'b0; end
            else if (g1 && p1_lock)                    begin m_own_vld = 1'b1; m_own = 1'b1; end
            else if (!(m_own_vld && (m_own ? p1_lock : p0_lock))) m_own_vld = 1'b0;
            if (!p1_req || g1)            m_starve = 0;
            else if (m_starve < MAX_WAIT) m_starve++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    initial begin
        int first;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'(i) ^ 16'hA5C3;
            shadow[i] = 16'(i) ^ 16'hA5C3;
        end
        mem[8'h10]    = 16'hBEEF;
        shadow[8'h10] = 16'hBEEF;
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;

        // single p0 read
        p0_req = 1; p0_addr = 8'h10;
        step();
        p0_req = 0;
        repeat (3) step();

        // both ports request continuously: p1 forced in on the fifth cycle
        p0_req = 1; p1_req = 1; p1_addr = 8'h50;
        first = -1;
        for (int k = 0; k < 15; k++) begin
            p0_addr = 8'(8'h40 + k);
            step();
            if (obs_g1 && first < 0) first = k;
        end
        chk("forced_grant_at", first, MAX_WAIT);
        idle_inputs();
        repeat (3) step();

        // p1 locked write burst while p0 waits
        p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 8'h20; p1_wdata = 16'h1234;
        step();
        p0_req = 1; p0_addr = 8'h21;
        step(); step();
        chk("lock_denies_p0", {31'b0, obs_g0}, 32'd0);
        p1_req = 0; p1_lock = 0;
        step();
        chk("release_grants_p0", {31'b0, obs_g0}, 32'd1);
        p0_addr = 8'h20;
        step();
        p0_req = 0;
        repeat (3) step();

        // write then read same address back to back
        p0_req = 1; p0_we = 1; p0_addr = 8'h30; p0_wdata = 16'h5A5A;
        step();
        p0_we = 0;
        step();
        p0_req = 0;
        repeat (3) step();

        // reset right after a p1 read grant flushes the response
        p1_req = 1; p1_addr = 8'h44;
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ram_rd", {31'b0, ram_rd}, 32'd0);
        chk("rst_raddr", {24'b0, ram_raddr}, 32'd0);
        chk("rst_wdata", {16'b0, ram_wdata}, 32'd0);
        repeat (4) step();

        // starve counter restarts when p1 drops its request
        p0_req = 1; p0_addr = 8'h11; p1_req = 1; p1_addr = 8'h12;
        step(); step();
        p1_req = 0;
        step();
        p1_req = 1;
        first = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_g1 && first < 0) first = k;
        end
        chk("starve_restart", first, MAX_WAIT);
        idle_inputs();
        repeat (3) step();

        // random traffic, each request held until granted
        for (int k = 0; k < 400; k++) begin
            if (!p0_req || obs_g0) begin
                p0_req = ($urandom_range(0, 3) != 0);
                p0_we = $urandom_range(0, 1) == 1;
                p0_addr = 8'($urandom_range(0, 7));
                p0_wdata = 16'($urandom);
            end
            if (!p1_req || obs_g1) begin
                p1_req = ($urandom_range(0, 2) != 0);
                p1_we = $urandom_range(0, 1) == 1;
                p1_addr = 8'($urandom_range(0, 7));
                p1_wdata = 16'($urandom);
            end
            p0_lock = ($urandom_range(0, 5) == 0);
            p1_lock = ($urandom_range(0, 5) == 0);
            step();
        end
        idle_inputs();
        repeat (5) step();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
